// File: rtl/date_bcd_counter_if.sv
// Signal bundle between the tick/load source and the BCD calendar block.
// The inputs are single-cycle enables sampled on every clock and always accepted,
// so there is no ready; load_err is the only response and pulses for one cycle.
interface date_bcd_counter_if;
   logic        day_tick;
   logic        swap_tick;
   logic        load;
   logic [7:0]  load_day;
   logic [7:0]  load_month;
   logic [15:0] load_year;
   logic        load_err;
   logic        date_year;
   logic [3:0]  num3;
   logic [3:0]  num2;
   logic [3:0]  num1;
   logic [3:0]  num0;

   modport master (
      output day_tick, swap_tick, load, load_day, load_month, load_year,
      input  load_err, date_year, num3, num2, num1, num0
   );

   modport slave (
      input  day_tick, swap_tick, load, load_day, load_month, load_year,
      output load_err, date_year, num3, num2, num1, num0
   );
endinterface

// File: rtl/date_bcd_counter.sv
// BCD calendar (DD.MM / YYYY) with Gregorian leap years, validated loads and a
// periodic date/year display toggle feeding a four-digit seven-segment driver.
module date_bcd_counter #(
   parameter logic [7:0]  RESET_DAY   = 8'h01,
   parameter logic [7:0]  RESET_MONTH = 8'h01,
   parameter logic [15:0] RESET_YEAR  = 16'h2021,
   parameter int          SWAP_DIV    = 2
) (
   input  logic                clk,
   input  logic                reset,
   date_bcd_counter_if.slave   bus
);

   localparam int SW = (SWAP_DIV > 1) ? $clog2(SWAP_DIV) : 1;

   logic [7:0]    day_q, month_q, day_n, month_n;
   logic [15:0]   year_q, year_n;
   logic [SW-1:0] swap_cnt_q, swap_cnt_n;
   logic          show_year_q, show_year_n;
   logic          err_n;
   logic [7:0]    cur_len;
   logic          load_ok;

   // Two-digit BCD divisibility by 4, decided on the digits alone.
   function automatic logic div4(input logic [3:0] t, input logic [3:0] o);
      if (!t[0]) return (o == 4'd0) || (o == 4'd4) || (o == 4'd8);
      else       return (o == 4'd2) || (o == 4'd6);
   endfunction

   function automatic logic is_leap(input logic [15:0] y);
      if (y[7:0] != 8'h00) return div4(y[7:4], y[3:0]);
      else                 return div4(y[15:12], y[11:8]);
   endfunction

   function automatic logic [7:0] month_len(input logic [7:0] m, input logic leap);
      case (m)
         8'h02:                      return leap ? 8'h29 : 8'h28;
         8'h04, 8'h06, 8'h09, 8'h11: return 8'h30;
         default:                    return 8'h31;
      endcase
   endfunction

   function automatic logic [7:0] inc_bcd8(input logic [7:0] v);
      if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
      else                return {v[7:4], v[3:0] + 4'd1};
   endfunction

   function automatic logic [15:0] inc_bcd16(input logic [15:0] v);
      logic [15:0] r;
      logic        c;
      r = v;
      c = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (c) begin
            if (r[i*4 +: 4] == 4'd9) begin
               r[i*4 +: 4] = 4'd0;
            end else begin
               r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
               c = 1'b0;
            end
         end
      end
      return r;
   endfunction

   function automatic logic digits_ok(input logic [31:0] v);
      logic ok;
      ok = 1'b1;
      for (int i = 0; i < 8; i++) begin
         if (v[i*4 +: 4] > 4'd9) ok = 1'b0;
      end
      return ok;
   endfunction

   // Valid BCD compares correctly as plain binary, so range checks need no conversion.
   always_comb begin
      cur_len = month_len(month_q, is_leap(year_q));
      load_ok = digits_ok({bus.load_year, bus.load_month, bus.load_day}) &&
                (bus.load_month >= 8'h01) && (bus.load_month <= 8'h12) &&
                (bus.load_day   >= 8'h01) &&
                (bus.load_day   <= month_len(bus.load_month, is_leap(bus.load_year)));
   end

   always_comb begin
      day_n       = day_q;
      month_n     = month_q;
      year_n      = year_q;
      err_n       = 1'b0;
      swap_cnt_n  = swap_cnt_q;
      show_year_n = show_year_q;

      if (bus.load) begin
         if (load_ok) begin
            day_n   = bus.load_day;
            month_n = bus.load_month;
            year_n  = bus.load_year;
         end else begin
            err_n = 1'b1;
         end
      end else if (bus.day_tick) begin
         if (day_q >= cur_len) begin
            day_n = 8'h01;
            if (month_q == 8'h12) begin
               month_n = 8'h01;
               year_n  = inc_bcd16(year_q);
            end else begin
               month_n = inc_bcd8(month_q);
            end
         end else begin
            day_n = inc_bcd8(day_q);
         end
      end

      if (bus.swap_tick) begin
         if (swap_cnt_q == SW'(SWAP_DIV - 1)) begin
            swap_cnt_n  = '0;
            show_year_n = ~show_year_q;
         end else begin
            swap_cnt_n = swap_cnt_q + SW'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         day_q       <= RESET_DAY;
         month_q     <= RESET_MONTH;
         year_q      <= RESET_YEAR;
         swap_cnt_q  <= '0;
         show_year_q <= 1'b0;
      end else begin
         day_q       <= day_n;
         month_q     <= month_n;
         year_q      <= year_n;
         swap_cnt_q  <= swap_cnt_n;
         show_year_q <= show_year_n;
      end
   end

   // Display registers follow the state one clock later; load_err answers the load directly.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bus.load_err  <= 1'b0;
         bus.date_year <= 1'b0;
         bus.num3      <= RESET_DAY[7:4];
         bus.num2      <= RESET_DAY[3:0];
         bus.num1      <= RESET_MONTH[7:4];
         bus.num0      <= RESET_MONTH[3:0];
      end else begin
         bus.load_err  <= err_n;
         bus.date_year <= show_year_q;
         if (show_year_q) begin
            bus.num3 <= year_q[15:12];
            bus.num2 <= year_q[11:8];
            bus.num1 <= year_q[7:4];
            bus.num0 <= year_q[3:0];
         end else begin
            bus.num3 <= day_q[7:4];
            bus.num2 <= day_q[3:0];
            bus.num1 <= month_q[7:4];
            bus.num0 <= month_q[3:0];
         end
      end
   end

endmodule
